// File: rtl/rms_pkg.sv
// Shared constants and types for the RMS mean-square reducer and the RMSNorm stage.
package rms_pkg;

  localparam int DEF_DW     = 16;
  localparam int DEF_FRAC   = 8;
  localparam int DEF_LOG2_N = 6;

  localparam int SQ_W  = 2 * DEF_DW;
  localparam int ACC_W = 2 * DEF_DW + DEF_LOG2_N;

  typedef logic signed [DEF_DW-1:0] elem_t;
  typedef logic        [SQ_W-1:0]   sq_t;
  typedef logic        [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/rms_square_stage.sv
// S1 of the reducer: registers the element square and its end-of-vector tag.
module rms_square_stage
  import rms_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic            in_is_last,
  input  logic            out_free,
  output logic            in_ready,
  output logic            sq_valid,
  output logic [2*DW-1:0] sq_data,
  output logic            sq_last,
  output logic            sq_adv
);

  logic                   accept;
  logic signed [2*DW-1:0] prod;

  // A last entry may only leave S1 when the output register can take its result.
  assign sq_adv   = !sq_valid || !sq_last || out_free;
  assign in_ready = sq_adv;
  assign accept   = in_valid && sq_adv;
  assign prod     = $signed(in_data) * $signed(in_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq_valid <= 1'b0;
      sq_data  <= '0;
      sq_last  <= 1'b0;
    end else if (sq_adv) begin
      sq_valid <= accept;
      if (accept) begin
        sq_data <= prod;
        sq_last <= in_is_last;
      end
    end
  end

endmodule

// File: rtl/rms_sumsq_reduce.sv
// Streams N signed elements and emits mean(x^2)+EPS per vector; RMS_LAST_CHECK_EN
// enables a sticky check of in_last against the element count.
module rms_sumsq_reduce
  import rms_pkg::*;
#(
  parameter int              DW     = DEF_DW,
  parameter int              FRAC   = DEF_FRAC,
  parameter int              LOG2_N = DEF_LOG2_N,
  parameter logic [2*DW-1:0] EPS    = (2*DW)'(1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data,
  output logic            err_last
);

  localparam int SQ_BITS  = 2 * DW;
  localparam int ACC_BITS = 2 * DW + LOG2_N;

  logic [LOG2_N-1:0]   count;
  logic [ACC_BITS-1:0] acc;
  logic [ACC_BITS-1:0] acc_sum;
  logic [SQ_BITS-1:0]  sq_data;
  logic [SQ_BITS-1:0]  mean;
  logic [SQ_BITS:0]    mean_eps;
  logic                sq_valid;
  logic                sq_last;
  logic                sq_adv;
  logic                is_last_in;
  logic                in_accept;
  logic                consume;

  assign is_last_in = &count;
  assign in_accept  = in_valid && in_ready;

  rms_square_stage #(
    .DW(DW)
  ) u_square (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_is_last(is_last_in),
    .out_free  (!out_valid || out_ready),
    .in_ready  (in_ready),
    .sq_valid  (sq_valid),
    .sq_data   (sq_data),
    .sq_last   (sq_last),
    .sq_adv    (sq_adv)
  );

  assign consume  = sq_valid && sq_adv;
  assign acc_sum  = acc + ACC_BITS'(sq_data);
  assign mean     = acc_sum[ACC_BITS-1:LOG2_N];
  assign mean_eps = {1'b0, mean} + {1'b0, EPS};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (in_accept) begin
      count <= count + 1'b1;
    end
  end

  // The final sum bypasses acc so the next vector can start accumulating from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (consume) begin
      acc <= sq_last ? '0 : acc_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (consume && sq_last) begin
      out_valid <= 1'b1;
      out_data  <= mean_eps[SQ_BITS] ? '1 : mean_eps[SQ_BITS-1:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef RMS_LAST_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_last <= 1'b0;
    end else if (in_accept && (in_last != is_last_in)) begin
      err_last <= 1'b1;
    end
  end

  logic unused_cfg;
  assign unused_cfg = (FRAC > DW);
`else
  assign err_last = 1'b0;

  logic unused_cfg;
  assign unused_cfg = in_last ^ (FRAC > DW);
`endif

endmodule
